// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the shared transmitter arbiter.
// master = arbiter side, slave = requesters plus uart side.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_byte;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              transmit;
   logic [7:0]        tx_byte;
   logic              is_transmitting;
   logic [GW-1:0]     grant_id;
   logic              locked;
   logic              start_err;

   modport master (
      input  req_valid,
      input  req_byte,
      input  req_last,
      input  is_transmitting,
      output req_ready,
      output transmit,
      output tx_byte,
      output grant_id,
      output locked,
      output start_err
   );

   modport slave (
      output req_valid,
      output req_byte,
      output req_last,
      output is_transmitting,
      input  req_ready,
      input  transmit,
      input  tx_byte,
      input  grant_id,
      input  locked,
      input  start_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte UART transmitter.
// Packet locking keeps multi-byte messages contiguous.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int START_TMO = 16,
   parameter int LOCK_TMO  = 4096
) (
   input logic               clk,
   input logic               rstn,
   uart_tx_arbiter_if.master bus
);
   localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SCW = $clog2(START_TMO + 1);
   localparam int LCW = $clog2(LOCK_TMO + 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOAD      = 2'd1;
   localparam logic [1:0] WAIT_BUSY = 2'd2;
   localparam logic [1:0] WAIT_IDLE = 2'd3;

   logic [1:0]      state;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   gid;
   logic [7:0]      byte_q;
   logic            lock_q;
   logic            err_q;
   logic [SCW-1:0]  wb_cnt;
   logic [LCW-1:0]  lk_cnt;

   logic            win_found;
   logic [GW-1:0]   win;
   logic [GW-1:0]   sel;
   logic [7:0]      sel_byte;
   logic            sel_last;
   logic [NREQ-1:0] ready;
   logic            xfer;
   logic            own_valid;

   // Round-robin search starting just above the last winner
   always_comb begin
      win_found = 1'b0;
      win       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_found && bus.req_valid[j]) begin
            win_found = 1'b1;
            win       = GW'(j);
         end
      end
   end

   // Ready strobe: one-hot, only in IDLE with the uart quiet
   always_comb begin
      ready     = '0;
      own_valid = bus.req_valid[gid];
      sel       = lock_q ? gid : win;
      if (rstn && state == IDLE &&
          !bus.is_transmitting) begin
         if (lock_q) begin
            if (own_valid) ready[gid] = 1'b1;
         end else if (win_found) begin
            ready[win] = 1'b1;
         end
      end
      xfer = |ready;
   end

   // Byte and last flag of the selected requester
   always_comb begin
      sel_byte = 8'h00;
      sel_last = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel == GW'(k)) begin
            sel_byte = bus.req_byte[8*k +: 8];
            sel_last = bus.req_last[k];
         end
      end
   end

   // Byte sequencing FSM with start timeout
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         wb_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer) state <= LOAD;
            end
            LOAD: begin
               wb_cnt <= '0;
               state  <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.is_transmitting) begin
                  state <= WAIT_IDLE;
               end else if (wb_cnt ==
                            SCW'(START_TMO - 1)) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  wb_cnt <= wb_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (!bus.is_transmitting) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Grant bookkeeping: latch byte, owner and rr pointer
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr    <= GW'(NREQ - 1);
         gid    <= '0;
         byte_q <= 8'h00;
      end else if (xfer) begin
         ptr    <= sel;
         gid    <= sel;
         byte_q <= sel_byte;
      end
   end

   // Packet lock with idle timeout on the owner
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_q <= 1'b0;
         lk_cnt <= '0;
      end else if (xfer) begin
         lock_q <= !sel_last;
         lk_cnt <= '0;
      end else if (!lock_q) begin
         lk_cnt <= '0;
      end else if (state == IDLE && !own_valid) begin
         if (lk_cnt == LCW'(LOCK_TMO - 1)) begin
            lock_q <= 1'b0;
            lk_cnt <= '0;
         end else begin
            lk_cnt <= lk_cnt + 1'b1;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.transmit  = (state == LOAD);
   assign bus.tx_byte   = byte_q;
   assign bus.grant_id  = gid;
   assign bus.locked    = lock_q;
   assign bus.start_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart echo model.
// Vector table for arbitration, hand sequences for timeouts/reset.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int STMO = 16;
   localparam int LTMO = 4096;
   localparam int BAUD = 52;

   logic clk;
   logic rstn;
   logic echo_en;
   int   checks;
   int   errors;
   int   tx_pulses;
   int   rdy0_pulses;
   int   bad_ready;
   int   ucnt;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .NREQ(NREQ),
      .START_TMO(STMO),
      .LOCK_TMO(LTMO)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart model: busy for BAUD cycles after a transmit pulse
   always @(posedge clk) begin
      if (!rstn) begin
         bus.is_transmitting <= 1'b0;
         ucnt <= 0;
      end else if (echo_en && bus.transmit) begin
         bus.is_transmitting <= 1'b1;
         ucnt <= BAUD - 1;
      end else if (ucnt != 0) begin
         ucnt <= ucnt - 1;
      end else begin
         bus.is_transmitting <= 1'b0;
      end
   end

   // ready must be one-hot and only with valid high
   always @(negedge clk) begin
      if (bus.transmit) tx_pulses++;
      if (bus.req_ready[0]) rdy0_pulses++;
      if ((bus.req_ready & ~bus.req_valid) != 0 ||
          (bus.req_ready & (bus.req_ready - 1)) != 0)
         bad_ready++;
   end

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] bytes;
      logic [3:0]  last;
      logic [3:0]  rdy;
      logic [1:0]  gid;
      logic [7:0]  tbyte;
      logic        lock;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic wait_xfer(output bit ok,
                            output logic [3:0] r,
                            output int cyc);
      ok  = 1'b0;
      r   = 4'h0;
      cyc = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         cyc = k + 1;
         if ((bus.req_ready & bus.req_valid) != 0) begin
            ok = 1'b1;
            r  = bus.req_ready;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   bit         ok;
   logic [3:0] r;
   int         cyc;
   int         n;
   bit         early;

   initial begin
      checks = 0; errors = 0;
      tx_pulses = 0; rdy0_pulses = 0; bad_ready = 0;
      echo_en = 1'b1;
      rstn = 1'b0;
      bus.req_valid = '0;
      bus.req_byte  = '0;
      bus.req_last  = '0;

      tv[0]  = '{0, 4'b0001, 32'h00000041, 4'hF,
                 4'b0001, 2'd0, 8'h41, 0};
      tv[1]  = '{0, 4'b0001, 32'h00000042, 4'hF,
                 4'b0001, 2'd0, 8'h42, 0};
      tv[2]  = '{1, 4'b1111, 32'h13121110, 4'hF,
                 4'b0001, 2'd0, 8'h10, 0};
      tv[3]  = '{0, 4'b1111, 32'h13121110, 4'hF,
                 4'b0010, 2'd1, 8'h11, 0};
      tv[4]  = '{0, 4'b1111, 32'h13121110, 4'hF,
                 4'b0100, 2'd2, 8'h12, 0};
      tv[5]  = '{0, 4'b1111, 32'h13121110, 4'hF,
                 4'b1000, 2'd3, 8'h13, 0};
      tv[6]  = '{0, 4'b1111, 32'h13121110, 4'hF,
                 4'b0001, 2'd0, 8'h10, 0};
      tv[7]  = '{0, 4'b0111, 32'h0022A120, 4'b1101,
                 4'b0010, 2'd1, 8'hA1, 1};
      tv[8]  = '{0, 4'b0111, 32'h0022A220, 4'b1101,
                 4'b0010, 2'd1, 8'hA2, 1};
      tv[9]  = '{0, 4'b0111, 32'h0022A320, 4'hF,
                 4'b0010, 2'd1, 8'hA3, 0};
      tv[10] = '{0, 4'b0111, 32'h0022A320, 4'hF,
                 4'b0100, 2'd2, 8'h22, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_transmit", 32'(bus.transmit), 32'h0);
      chk("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
      chk("rst_grant", 32'(bus.grant_id), 32'h0);
      chk("rst_locked", 32'(bus.locked), 32'h0);
      chk("rst_start_err", 32'(bus.start_err), 32'h0);
      rstn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         if (tv[i].rst) do_reset();
         bus.req_valid = tv[i].valid;
         bus.req_byte  = tv[i].bytes;
         bus.req_last  = tv[i].last;
         wait_xfer(ok, r, cyc);
         chk($sformatf("v%0d_xfer", i), 32'(ok), 32'h1);
         chk($sformatf("v%0d_ready", i),
             32'(r), 32'(tv[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_grant", i),
             32'(bus.grant_id), 32'(tv[i].gid));
         chk($sformatf("v%0d_byte", i),
             32'(bus.tx_byte), 32'(tv[i].tbyte));
         chk($sformatf("v%0d_lock", i),
             32'(bus.locked), 32'(tv[i].lock));
         chk($sformatf("v%0d_tx_hi", i),
             32'(bus.transmit), 32'h1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_tx_lo", i),
             32'(bus.transmit), 32'h0);
         if (i == 1) begin
            chk("t1_tx_pulses", 32'(tx_pulses), 32'd2);
            chk("t1_rdy0_pulses", 32'(rdy0_pulses), 32'd2);
         end
      end

      // lock by req2, then owner goes silent
      bus.req_valid = 4'b0100;
      bus.req_byte  = 32'h00240000;
      bus.req_last  = 4'b1011;
      wait_xfer(ok, r, cyc);
      chk("t4_ready", 32'(r), 32'b0100);
      @(posedge clk);
      #1;
      chk("t4_locked", 32'(bus.locked), 32'h1);
      bus.req_valid = 4'b0001;
      bus.req_byte  = 32'h00240030;
      n = 0;
      early = 1'b0;
      while (n < BAUD + LTMO + 50) begin
         @(posedge clk);
         #1;
         n++;
         if (!bus.locked) break;
         if (bus.req_ready[0]) early = 1'b1;
      end
      chk("t4_unlock_cycle", 32'(n), 32'(BAUD + 2 + LTMO));
      chk("t4_no_early_ready", 32'(early), 32'h0);
      wait_xfer(ok, r, cyc);
      chk("t4_req0_ready", 32'(r), 32'b0001);
      chk("t4_req0_latency", 32'(cyc), 32'd1);
      @(posedge clk);
      #1;
      chk("t4_grant", 32'(bus.grant_id), 32'h0);
      chk("t4_byte", 32'(bus.tx_byte), 32'h30);

      // start timeout with a dead uart
      bus.req_valid = 4'b0000;
      repeat (BAUD + 10) @(posedge clk);
      #1;
      echo_en = 1'b0;
      bus.req_valid = 4'b1000;
      bus.req_byte  = 32'h5A000000;
      bus.req_last  = 4'hF;
      wait_xfer(ok, r, cyc);
      chk("t5_ready", 32'(r), 32'b1000);
      @(posedge clk);
      #1;
      chk("t5_transmit", 32'(bus.transmit), 32'h1);
      bus.req_byte = 32'h5B000000;
      for (int k = 1; k <= STMO + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == STMO)
            chk("t5_err_before", 32'(bus.start_err), 32'h0);
      end
      chk("t5_err_after", 32'(bus.start_err), 32'h1);
      echo_en = 1'b1;
      wait_xfer(ok, r, cyc);
      chk("t5_idle_ready", 32'(r), 32'b1000);
      chk("t5_idle_latency", 32'(cyc), 32'd1);
      @(posedge clk);
      #1;
      chk("t5_next_byte", 32'(bus.tx_byte), 32'h5B);
      repeat (BAUD + 10) @(posedge clk);
      #1;
      chk("t5_err_sticky", 32'(bus.start_err), 32'h1);

      // reset in the middle of WAIT_IDLE
      bus.req_valid = 4'b0010;
      bus.req_byte  = 32'h00006100;
      bus.req_last  = 4'b1101;
      wait_xfer(ok, r, cyc);
      chk("t6_ready", 32'(r), 32'b0010);
      @(posedge clk);
      #1;
      chk("t6_locked", 32'(bus.locked), 32'h1);
      repeat (10) @(posedge clk);
      #1;
      bus.req_valid = 4'b1111;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_transmit", 32'(bus.transmit), 32'h0);
      chk("t6_tx_byte", 32'(bus.tx_byte), 32'h0);
      chk("t6_grant", 32'(bus.grant_id), 32'h0);
      chk("t6_locked_clr", 32'(bus.locked), 32'h0);
      chk("t6_err_clr", 32'(bus.start_err), 32'h0);
      chk("t6_ready_lo", 32'(bus.req_ready), 32'h0);
      rstn = 1'b1;
      wait_xfer(ok, r, cyc);
      chk("t6_first_grant", 32'(r), 32'b0001);
      @(posedge clk);
      #1;
      chk("t6_grant_id", 32'(bus.grant_id), 32'h0);

      chk("ready_onehot_valid", 32'(bad_ready), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
